// File: rtl/mux_scan_n_if.sv
// mux_scan_n_if: data, control and status bundle of the scanning mux.
// MUX_SCAN_MASK_EN adds the CH_EN channel-enable vector.
interface mux_scan_n_if #(
   parameter int BITS     = 4,
   parameter int CHANNELS = 8
);
   localparam int SEL_W = $clog2(CHANNELS);

   logic [CHANNELS*BITS-1:0] D;
   logic [SEL_W-1:0]         SEL;
   logic                     MODE;
   logic                     HOLD;
`ifdef MUX_SCAN_MASK_EN
   logic [CHANNELS-1:0]      CH_EN;
`endif
   logic [BITS-1:0]          MUX_OUT;
   logic [SEL_W-1:0]         CH;
   logic                     CH_CHANGE;
   logic                     WRAP;
   logic                     SEL_ERR;

`ifdef MUX_SCAN_MASK_EN
   modport master (
      output D, SEL, MODE, HOLD, CH_EN,
      input  MUX_OUT, CH, CH_CHANGE, WRAP, SEL_ERR
   );
   modport slave (
      input  D, SEL, MODE, HOLD, CH_EN,
      output MUX_OUT, CH, CH_CHANGE, WRAP, SEL_ERR
   );
`else
   modport master (
      output D, SEL, MODE, HOLD,
      input  MUX_OUT, CH, CH_CHANGE, WRAP, SEL_ERR
   );
   modport slave (
      input  D, SEL, MODE, HOLD,
      output MUX_OUT, CH, CH_CHANGE, WRAP, SEL_ERR
   );
`endif
endinterface

// File: rtl/mux_scan_n.sv
// mux_scan_n: registered N-channel mux, manual select or timed auto-scan.
// MUX_SCAN_MASK_EN: scan skips channels disabled in CH_EN.
module mux_scan_n #(
   parameter int BITS     = 4,
   parameter int CHANNELS = 8,
   parameter int DWELL    = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   mux_scan_n_if.slave bus
);
   localparam int SEL_W = $clog2(CHANNELS);
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W:0]   NCH      = (SEL_W+1)'(CHANNELS);

   typedef enum logic [1:0] {S_MANUAL, S_SCAN, S_PAUSE} state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    ch_q, ch_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_base;
   logic [BITS-1:0]     out_q, out_d;
   logic                chg_q, chg_d;
   logic                wrap_q, wrap_d;
   logic                err_q, err_d;
   logic [CHANNELS-1:0] en;
   logic                any_en;
   logic                sel_ok;
   logic [SEL_W-1:0]    scan_nxt;
   logic                scan_wrap;
   logic [SEL_W:0]      sum;
   logic [SEL_W-1:0]    idx;
   logic [BITS-1:0]     d_w [CHANNELS];

`ifdef MUX_SCAN_MASK_EN
   assign en = bus.CH_EN;
`else
   assign en = '1;
`endif
   assign any_en = |en;
   assign sel_ok = ({1'b0, bus.SEL} < NCH) && en[bus.SEL];

   // Unpack the flat input bus into one word per channel.
   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         d_w[k] = bus.D[k*BITS +: BITS];
      end
   end

   // Nearest enabled channel above ch_q; flags passing the top index.
   always_comb begin
      scan_nxt  = ch_q;
      scan_wrap = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int i = CHANNELS; i >= 1; i--) begin
         sum = {1'b0, ch_q} + (SEL_W+1)'(i);
         if (sum >= NCH) begin
            idx = SEL_W'(sum - NCH);
         end else begin
            idx = sum[SEL_W-1:0];
         end
         if (en[idx]) begin
            scan_nxt  = idx;
            scan_wrap = (sum >= NCH);
         end
      end
   end

   // Mode decode plus channel, dwell and output next state.
   always_comb begin
      state_d  = S_MANUAL;
      unique case (1'b1)
         !bus.MODE:             state_d = S_MANUAL;
         bus.MODE && !bus.HOLD: state_d = S_SCAN;
         bus.MODE && bus.HOLD:  state_d = S_PAUSE;
      endcase
      cnt_base = (state_q == S_MANUAL) ? '0 : cnt_q;
      ch_d     = ch_q;
      cnt_d    = cnt_base;
      err_d    = 1'b0;
      wrap_d   = 1'b0;
      out_d    = '0;
      unique case (state_d)
         S_MANUAL: begin
            cnt_d = '0;
            if (sel_ok) begin
               ch_d = bus.SEL;
            end else begin
               err_d = 1'b1;
            end
         end
         S_SCAN: begin
            if (any_en) begin
               if (cnt_base == CNT_LAST) begin
                  cnt_d  = '0;
                  ch_d   = scan_nxt;
                  wrap_d = scan_wrap;
               end else begin
                  cnt_d = cnt_base + CNT_W'(1);
               end
            end
         end
         default: ;
      endcase
      out_d = d_w[ch_d];
      if (err_d || (state_d == S_SCAN && !any_en)) begin
         out_d = '1;
      end
      chg_d = (ch_d != ch_q);
   end

   // State, channel and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_MANUAL;
         ch_q    <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         chg_q   <= 1'b0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         chg_q   <= chg_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

   assign bus.MUX_OUT   = out_q;
   assign bus.CH        = ch_q;
   assign bus.CH_CHANGE = chg_q;
   assign bus.WRAP      = wrap_q;
   assign bus.SEL_ERR   = err_q;
endmodule
